// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode constants: opcodes, ALU-op encodings, branch funct3 codes and the
// control bundle produced by the ID stage.
package rv_decode_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OpcRtype  = 7'b0110011;
    localparam logic [6:0] OpcIalu   = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    typedef enum logic [1:0] {
        AluAdd    = 2'b00,
        AluBranch = 2'b01,
        AluRtype  = 2'b10,
        AluItype  = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    typedef struct packed {
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// 32-entry register file: two combinational read ports, one write port, async clear.
// Define WB_BYPASS_EN to forward the same-cycle write-back data onto matching reads.
module id_regfile #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [32];
    logic [4:0]      raddr  [2];
    logic [XLEN-1:0] rdata  [2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs_q[raddr[p]];
            // x0 and the reset window both read as zero, overriding any bypass.
            if ((raddr[p] == 5'd0) || !rst_ni) begin
                rdata[p] = '0;
            end
`ifdef WB_BYPASS_EN
            else if (we_i && (raddr[p] == waddr_i)) begin
                rdata[p] = wdata_i;
            end
`endif
        end
    end

    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];

endmodule

// File: rtl/id_pipe_stage.sv
// RV32I instruction-decode stage: register file, control decode, immediate generation,
// early branch/JAL resolution and hazard bubbles. WB_BYPASS_EN selects regfile write-through.
module id_pipe_stage #(
    parameter int unsigned XLEN = rv_decode_pkg::XLEN,
    parameter int unsigned PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_plus4,
    input  logic [31:0]     instr,
    input  logic            mem_wb_reg_write,
    input  logic [4:0]      mem_wb_write_reg_addr,
    input  logic [XLEN-1:0] mem_wb_write_back_data,
    input  logic            Data_Hazard,
    input  logic            Control_Hazard,
    output logic [XLEN-1:0] reg1,
    output logic [XLEN-1:0] reg2,
    output logic [XLEN-1:0] imm_value,
    output logic [PC_W-1:0] branch_address,
    output logic [PC_W-1:0] jump_address,
    output logic            branch_taken,
    output logic [4:0]      destination_reg,
    output logic            mem_to_reg,
    output logic            mem_read,
    output logic            mem_write,
    output logic            alu_src,
    output logic            reg_write,
    output logic            jump,
    output logic [1:0]      alu_op
);
    import rv_decode_pkg::*;

    logic [6:0]      opcode;
    logic [31:0]     imm_i, imm_s, imm_b, imm_j, imm_sel;
    logic [4:0]      rd_dec;
    logic            is_branch;
    logic            cond;
    logic            bubble;
    logic [PC_W-1:0] pc;
    ctrl_t           ctrl_dec, ctrl_out;

    assign opcode = instr[6:0];

    id_regfile #(
        .XLEN(XLEN)
    ) u_regfile (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (mem_wb_reg_write),
        .waddr_i (mem_wb_write_reg_addr),
        .wdata_i (mem_wb_write_back_data),
        .raddr1_i(instr[19:15]),
        .raddr2_i(instr[24:20]),
        .rdata1_o(reg1),
        .rdata2_o(reg2)
    );

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        ctrl_dec  = '0;
        imm_sel   = '0;
        rd_dec    = 5'd0;
        is_branch = 1'b0;
        case (opcode)
            OpcRtype: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = AluRtype;
                rd_dec             = instr[11:7];
            end
            OpcIalu: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.alu_op    = AluItype;
                imm_sel            = imm_i;
                rd_dec             = instr[11:7];
            end
            OpcLoad: begin
                ctrl_dec.mem_read   = 1'b1;
                ctrl_dec.mem_to_reg = 1'b1;
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.alu_src    = 1'b1;
                ctrl_dec.alu_op     = AluAdd;
                imm_sel             = imm_i;
                rd_dec              = instr[11:7];
            end
            OpcStore: begin
                ctrl_dec.mem_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.alu_op    = AluAdd;
                imm_sel            = imm_s;
            end
            OpcBranch: begin
                ctrl_dec.alu_op = AluBranch;
                imm_sel         = imm_b;
                is_branch       = 1'b1;
            end
            OpcJal: begin
                ctrl_dec.jump      = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                imm_sel            = imm_j;
                rd_dec             = instr[11:7];
            end
            default: ;
        endcase
    end

    assign imm_value = XLEN'($signed(imm_sel));

    always_comb begin
        cond = 1'b0;
        case (instr[14:12])
            F3Beq:   cond = (reg1 == reg2);
            F3Bne:   cond = (reg1 != reg2);
            F3Blt:   cond = ($signed(reg1) < $signed(reg2));
            F3Bge:   cond = ($signed(reg1) >= $signed(reg2));
            F3Bltu:  cond = (reg1 < reg2);
            F3Bgeu:  cond = (reg1 >= reg2);
            default: cond = 1'b0;
        endcase
    end

    // Targets are always driven and wrap modulo 2^PC_W.
    assign pc             = pc_plus4 - PC_W'(4);
    assign branch_address = pc + imm_value[PC_W-1:0];
    assign jump_address   = pc + imm_j[PC_W-1:0];

    assign bubble          = Data_Hazard | Control_Hazard | ~reset;
    assign ctrl_out        = bubble ? '0 : ctrl_dec;
    assign branch_taken    = ~bubble & is_branch & cond;
    assign destination_reg = bubble ? 5'd0 : rd_dec;

    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign mem_read   = ctrl_out.mem_read;
    assign mem_write  = ctrl_out.mem_write;
    assign alu_src    = ctrl_out.alu_src;
    assign reg_write  = ctrl_out.reg_write;
    assign jump       = ctrl_out.jump;
    assign alu_op     = ctrl_out.alu_op;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Scoreboard bench for id_pipe_stage: the driver queues hand-computed expectations and a
// negedge monitor pops and compares them against the decode outputs.
module tb_id_pipe_stage;

    localparam int unsigned PcW = 10;
`ifdef WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    // {mem_to_reg, mem_read, mem_write, alu_src, reg_write, jump, alu_op}
    localparam logic [7:0] CtlN = 8'b0000_0000;
    localparam logic [7:0] CtlR = 8'b0000_1010;
    localparam logic [7:0] CtlI = 8'b0001_1011;
    localparam logic [7:0] CtlL = 8'b1101_1000;
    localparam logic [7:0] CtlS = 8'b0011_0000;
    localparam logic [7:0] CtlB = 8'b0000_0001;
    localparam logic [7:0] CtlJ = 8'b0000_1100;

    localparam logic [31:0] InsAdd  = 32'h006281B3;
    localparam logic [31:0] InsAddi = 32'hFFF00093;
    localparam logic [31:0] InsBeq  = 32'h00000463;
    localparam logic [31:0] InsBne  = 32'h00001463;
    localparam logic [31:0] InsJal  = 32'h010000EF;
    localparam logic [31:0] InsLw   = 32'h0040A103;
    localparam logic [31:0] InsSw   = 32'h0062A423;
    localparam logic [31:0] InsX7   = 32'h00038413;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [PcW-1:0]  pc_plus4 = '0;
    logic [31:0]     instr = '0;
    logic            mem_wb_reg_write = 1'b0;
    logic [4:0]      mem_wb_write_reg_addr = '0;
    logic [31:0]     mem_wb_write_back_data = '0;
    logic            Data_Hazard = 1'b0;
    logic            Control_Hazard = 1'b0;
    logic [31:0]     reg1, reg2, imm_value;
    logic [PcW-1:0]  branch_address, jump_address;
    logic            branch_taken;
    logic [4:0]      destination_reg;
    logic            mem_to_reg, mem_read, mem_write, alu_src, reg_write, jump;
    logic [1:0]      alu_op;

    id_pipe_stage #(
        .XLEN(32),
        .PC_W(PcW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .pc_plus4              (pc_plus4),
        .instr                 (instr),
        .mem_wb_reg_write      (mem_wb_reg_write),
        .mem_wb_write_reg_addr (mem_wb_write_reg_addr),
        .mem_wb_write_back_data(mem_wb_write_back_data),
        .Data_Hazard           (Data_Hazard),
        .Control_Hazard        (Control_Hazard),
        .reg1                  (reg1),
        .reg2                  (reg2),
        .imm_value             (imm_value),
        .branch_address        (branch_address),
        .jump_address          (jump_address),
        .branch_taken          (branch_taken),
        .destination_reg       (destination_reg),
        .mem_to_reg            (mem_to_reg),
        .mem_read              (mem_read),
        .mem_write             (mem_write),
        .alu_src               (alu_src),
        .reg_write             (reg_write),
        .jump                  (jump),
        .alu_op                (alu_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [31:0]    r1;
        logic [31:0]    r2;
        logic [31:0]    imm;
        logic [PcW-1:0] ba;
        logic [PcW-1:0] ja;
        logic           bt;
        logic [4:0]     rd;
        logic [7:0]     ctl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] ctl;
            e   = exp_q.pop_front();
            ctl = {mem_to_reg, mem_read, mem_write, alu_src, reg_write, jump, alu_op};
            checks++;
            if (reg1 !== e.r1 || reg2 !== e.r2 || imm_value !== e.imm ||
                branch_address !== e.ba || jump_address !== e.ja ||
                branch_taken !== e.bt || destination_reg !== e.rd || ctl !== e.ctl) begin
                errors++;
                $display("FAIL %s: got r1=%h r2=%h imm=%h ba=%h ja=%h bt=%b rd=%0d ctl=%b | want r1=%h r2=%h imm=%h ba=%h ja=%h bt=%b rd=%0d ctl=%b",
                         e.name, reg1, reg2, imm_value, branch_address, jump_address,
                         branch_taken, destination_reg, ctl, e.r1, e.r2, e.imm, e.ba, e.ja,
                         e.bt, e.rd, e.ctl);
            end
        end
    end

    task automatic vec(input string n, input logic rst, input logic [PcW-1:0] p,
                       input logic [31:0] ins, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic dh, input logic ch,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [PcW-1:0] ba, input logic [PcW-1:0] ja, input logic bt,
                       input logic [4:0] rd, input logic [7:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        reset                  = rst;
        pc_plus4               = p;
        instr                  = ins;
        mem_wb_reg_write       = we;
        mem_wb_write_reg_addr  = wa;
        mem_wb_write_back_data = wd;
        Data_Hazard            = dh;
        Control_Hazard         = ch;
        e = '{name: n, r1: r1, r2: r2, imm: imm, ba: ba, ja: ja, bt: bt, rd: rd, ctl: ctl};
        exp_q.push_back(e);
    endtask

    initial begin
        //   name          rst p   instr     we wa  wdata         dh ch  r1            r2            imm           ba      ja      bt rd  ctl
        vec("rst_unknown", 0, 4,  32'h0,    0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'h0,        10'h0,  10'h0,  0, 0,  CtlN);
        vec("add_wb_x5",   1, 4,  InsAdd,   1, 5,  32'h12345678, 0, 0,  Byp ? 32'h12345678 : 32'h0,
                                                                                      32'h0,        32'h0,        10'h0,  10'h6,  0, 3,  CtlR);
        vec("add_x5",      1, 4,  InsAdd,   0, 0,  32'h0,        0, 0,  32'h12345678, 32'h0,        32'h0,        10'h0,  10'h6,  0, 3,  CtlR);
        vec("addi_m1",     1, 4,  InsAddi,  1, 6,  32'hFFFFFFFF, 0, 0,  32'h0,        32'h0,        32'hFFFFFFFF, 10'h3FF,10'h3FE,0, 1,  CtlI);
        vec("beq_taken",   1, 16, InsBeq,   0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'h8,        10'd20, 10'd12, 1, 0,  CtlB);
        vec("bne_not",     1, 16, InsBne,   0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'h8,        10'd20, 10'd12, 0, 0,  CtlB);
        vec("beq_wrap",    1, 0,  InsBeq,   0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'h8,        10'h004,10'h3FC,1, 0,  CtlB);
        vec("jal",         1, 8,  InsJal,   0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'd16,       10'd20, 10'd20, 0, 1,  CtlJ);
        vec("lw",          1, 4,  InsLw,    0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'h4,        10'd4,  10'd4,  0, 2,  CtlL);
        vec("lw_dhaz",     1, 4,  InsLw,    0, 0,  32'h0,        1, 0,  32'h0,        32'h0,        32'h4,        10'd4,  10'd4,  0, 0,  CtlN);
        vec("lw_chaz",     1, 4,  InsLw,    0, 0,  32'h0,        0, 1,  32'h0,        32'h0,        32'h4,        10'd4,  10'd4,  0, 0,  CtlN);
        vec("blt",         1, 4,  32'h0062C063, 0, 0, 32'h0,     0, 0,  32'h12345678, 32'hFFFFFFFF, 32'h0,        10'd0,  10'd6,  0, 0,  CtlB);
        vec("bge",         1, 4,  32'h0062D063, 0, 0, 32'h0,     0, 0,  32'h12345678, 32'hFFFFFFFF, 32'h0,        10'd0,  10'd6,  1, 0,  CtlB);
        vec("bltu",        1, 4,  32'h0062E063, 0, 0, 32'h0,     0, 0,  32'h12345678, 32'hFFFFFFFF, 32'h0,        10'd0,  10'd6,  1, 0,  CtlB);
        vec("bgeu",        1, 4,  32'h0062F063, 0, 0, 32'h0,     0, 0,  32'h12345678, 32'hFFFFFFFF, 32'h0,        10'd0,  10'd6,  0, 0,  CtlB);
        vec("f3_010",      1, 4,  32'h0062A063, 0, 0, 32'h0,     0, 0,  32'h12345678, 32'hFFFFFFFF, 32'h0,        10'd0,  10'd6,  0, 0,  CtlB);
        vec("bltu_chaz",   1, 4,  32'h0062E063, 0, 0, 32'h0,     0, 1,  32'h12345678, 32'hFFFFFFFF, 32'h0,        10'd0,  10'd6,  0, 0,  CtlN);
        vec("sw",          1, 4,  InsSw,    0, 0,  32'h0,        0, 0,  32'h12345678, 32'hFFFFFFFF, 32'h8,        10'd8,  10'd6,  0, 0,  CtlS);
        vec("x7_wb",       1, 4,  InsX7,    1, 7,  32'hAB,       0, 0,  Byp ? 32'hAB : 32'h0,
                                                                                      32'h0,        32'h0,        10'd0,  10'd0,  0, 8,  CtlI);
        vec("x7_after",    1, 4,  InsX7,    0, 0,  32'h0,        0, 0,  32'hAB,       32'h0,        32'h0,        10'd0,  10'd0,  0, 8,  CtlI);
        vec("wb_x0",       1, 4,  InsAddi,  1, 0,  32'hDEAD,     0, 0,  32'h0,        32'h0,        32'hFFFFFFFF, 10'h3FF,10'h3FE,0, 1,  CtlI);
        vec("x0_after",    1, 4,  InsAddi,  0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'hFFFFFFFF, 10'h3FF,10'h3FE,0, 1,  CtlI);
        vec("rst_mid",     0, 4,  InsSw,    0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'h8,        10'd8,  10'd6,  0, 0,  CtlN);
        vec("rst_cleared", 1, 4,  InsSw,    0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'h8,        10'd8,  10'd6,  0, 0,  CtlS);
        vec("x7_cleared",  1, 4,  InsX7,    0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        32'h0,        10'd0,  10'd0,  0, 8,  CtlI);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
